// File: rtl/aurora_rx_cell_filter.sv
// -----------------------------------------------------------------------------
// aurora_rx_cell_filter
//
// Receive-side packet filter for the Aurora 64b66b RX AXI-stream. Every valid
// beat goes into a local circular buffer. A packet becomes visible downstream
// only once the core reports a passing CRC. Packets that fail CRC, time out,
// are orphaned by a new packet, or overflow the buffer are rolled back and
// never reach the output.
//
// Ports
//   userClk, userRstN            : Aurora user clock, async active-low reset
//   axiRXtdata/tkeep/tlast/tValid: RX beat in (no backpressure)
//   axiCrcValid, axiCrcPass      : CRC result strobe and verdict
//   outTdata/Tkeep/Tlast/Tvalid  : filtered stream out, single output register
//   outTready                    : downstream ready
//   goodPktCount                 : saturating count of committed packets
//   crcErrCount                  : saturating count of CRC fail/timeout/orphan
//   overflowCount                : saturating count of buffer-full drops
// -----------------------------------------------------------------------------
module aurora_rx_cell_filter #(
    parameter int ADDR_WIDTH  = 5,
    parameter int CRC_TIMEOUT = 15
) (
    input  logic        userClk,
    input  logic        userRstN,
    input  logic [63:0] axiRXtdata,
    input  logic [7:0]  axiRXtkeep,
    input  logic        axiRXtlast,
    input  logic        axiRXtValid,
    input  logic        axiCrcValid,
    input  logic        axiCrcPass,
    output logic [63:0] outTdata,
    output logic [7:0]  outTkeep,
    output logic        outTlast,
    output logic        outTvalid,
    input  logic        outTready,
    output logic [15:0] goodPktCount,
    output logic [15:0] crcErrCount,
    output logic [15:0] overflowCount
);
    localparam int                  DEPTH_N      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH        = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [7:0]          TIMEOUT_LAST = 8'(CRC_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RECV, WAIT_CRC, DROP} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t              r_state, w_state_nxt;
    logic [ADDR_WIDTH:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [ADDR_WIDTH:0] r_commit_ptr, w_commit_ptr_nxt;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [ADDR_WIDTH:0] w_base;
    logic [7:0]          r_timer, w_timer_nxt;
    logic                w_try_write, w_wr_en, w_strobe_free;
    logic                w_inc_good, w_inc_crc, w_inc_ovf;
    logic [15:0]         r_good_cnt, r_crc_cnt, r_ovf_cnt;
    logic [72:0]         r_mem [DEPTH_N];
    logic [72:0]         r_out_word;
    logic                r_out_valid;
    logic                w_load;

    // -------------------------------------------------------------------------
    // Write-side FSM: next state, pointer updates and counter strobes.
    // w_base is where an incoming beat would land: wrPtr normally, commitPtr
    // once a pending packet has been rolled back (or wrPtr after a commit).
    // -------------------------------------------------------------------------
    // NOTE: always_comb uses blocking '=' and assigns every output a default
    // first, so w_base can be refined and then read in the same pass without
    // creating a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_commit_ptr_nxt = r_commit_ptr;
        w_timer_nxt      = 8'd0;
        w_base           = r_wr_ptr;
        w_try_write      = 1'b0;
        w_wr_en          = 1'b0;
        w_strobe_free    = 1'b1;
        w_inc_good       = 1'b0;
        w_inc_crc        = 1'b0;
        w_inc_ovf        = 1'b0;

        case (r_state)
            IDLE, RECV: w_try_write = axiRXtValid;
            WAIT_CRC: begin
                if (axiCrcValid) begin
                    // The strobe belongs to the pending packet; a beat in the
                    // same cycle starts a fresh packet after the verdict.
                    w_strobe_free = 1'b0;
                    w_state_nxt   = IDLE;
                    w_try_write   = axiRXtValid;
                    if (axiCrcPass) begin
                        w_commit_ptr_nxt = r_wr_ptr;
                        w_inc_good       = 1'b1;
                    end else begin
                        w_wr_ptr_nxt = r_commit_ptr;
                        w_base       = r_commit_ptr;
                        w_inc_crc    = 1'b1;
                    end
                end else if (axiRXtValid) begin
                    // Orphan: the new packet overwrites the uncommitted one.
                    w_wr_ptr_nxt = r_commit_ptr;
                    w_base       = r_commit_ptr;
                    w_inc_crc    = 1'b1;
                    w_try_write  = 1'b1;
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_wr_ptr_nxt = r_commit_ptr;
                    w_inc_crc    = 1'b1;
                    w_state_nxt  = IDLE;
                end else begin
                    w_timer_nxt = r_timer + 8'd1;
                end
            end
            DROP: begin
                if (axiRXtValid && axiRXtlast) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_try_write) begin
            if ((w_base - r_rd_ptr) == DEPTH) begin
                w_wr_ptr_nxt = w_commit_ptr_nxt;
                w_inc_ovf    = 1'b1;
                w_state_nxt  = axiRXtlast ? IDLE : DROP;
            end else begin
                w_wr_en      = 1'b1;
                w_wr_ptr_nxt = w_base + PTR_ONE;
                if (!axiRXtlast) begin
                    w_state_nxt = RECV;
                end else if (axiCrcValid && w_strobe_free) begin
                    // Verdict arrives with tlast: apply it without WAIT_CRC.
                    w_state_nxt = IDLE;
                    if (axiCrcPass) begin
                        w_commit_ptr_nxt = w_base + PTR_ONE;
                        w_inc_good       = 1'b1;
                    end else begin
                        w_wr_ptr_nxt = w_commit_ptr_nxt;
                        w_inc_crc    = 1'b1;
                    end
                end else begin
                    w_state_nxt = WAIT_CRC;
                    w_timer_nxt = 8'd0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the values from before the edge.
    always_ff @(posedge userClk or negedge userRstN) begin
        if (!userRstN) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_timer      <= 8'd0;
            r_good_cnt   <= 16'd0;
            r_crc_cnt    <= 16'd0;
            r_ovf_cnt    <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_commit_ptr <= w_commit_ptr_nxt;
            r_timer      <= w_timer_nxt;
            if (w_inc_good) r_good_cnt <= sat_inc(r_good_cnt);
            if (w_inc_crc)  r_crc_cnt  <= sat_inc(r_crc_cnt);
            if (w_inc_ovf)  r_ovf_cnt  <= sat_inc(r_ovf_cnt);
        end
    end

    // NOTE: the buffer array is deliberately not reset; pointers alone define
    // which entries are meaningful, and an unreset array maps onto RAM.
    always_ff @(posedge userClk) begin
        if (w_wr_en) r_mem[w_base[ADDR_WIDTH-1:0]] <= {axiRXtlast, axiRXtkeep, axiRXtdata};
    end

    // -------------------------------------------------------------------------
    // Read side: the output register is the registered memory read. It loads
    // whenever committed data exists and the register is empty or draining,
    // giving one beat per cycle and holding steady under backpressure.
    // Reads only cover committed entries, so rollbacks never disturb them.
    // -------------------------------------------------------------------------
    assign w_load = (r_commit_ptr != r_rd_ptr) && (!r_out_valid || outTready);

    always_ff @(posedge userClk or negedge userRstN) begin
        if (!userRstN) begin
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_rd_ptr    <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_word  <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
            r_rd_ptr    <= r_rd_ptr + PTR_ONE;
        end else if (outTready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign outTvalid     = r_out_valid;
    assign outTlast      = r_out_word[72];
    assign outTkeep      = r_out_word[71:64];
    assign outTdata      = r_out_word[63:0];
    assign goodPktCount  = r_good_cnt;
    assign crcErrCount   = r_crc_cnt;
    assign overflowCount = r_ovf_cnt;

endmodule

// File: tb/tb_aurora_rx_cell_filter.sv
// -----------------------------------------------------------------------------
// tb_aurora_rx_cell_filter
//
// Directed bench for aurora_rx_cell_filter (ADDR_WIDTH=3, CRC_TIMEOUT=15):
// good packet and commit latency, CRC fail, overflow, timeout with a late
// strobe, orphan rollback, verdict in the tlast cycle, 100 random packets
// under random backpressure, and asynchronous reset mid-packet.
// -----------------------------------------------------------------------------
module tb_aurora_rx_cell_filter;
    localparam int AW = 3;
    localparam int CT = 15;

    logic        userClk = 1'b0;
    logic        userRstN = 1'b0;
    logic [63:0] axiRXtdata;
    logic [7:0]  axiRXtkeep;
    logic        axiRXtlast;
    logic        axiRXtValid;
    logic        axiCrcValid;
    logic        axiCrcPass;
    logic [63:0] outTdata;
    logic [7:0]  outTkeep;
    logic        outTlast;
    logic        outTvalid;
    logic        outTready;
    logic [15:0] goodPktCount;
    logic [15:0] crcErrCount;
    logic [15:0] overflowCount;

    aurora_rx_cell_filter #(.ADDR_WIDTH(AW), .CRC_TIMEOUT(CT)) dut (
        .userClk      (userClk),
        .userRstN     (userRstN),
        .axiRXtdata   (axiRXtdata),
        .axiRXtkeep   (axiRXtkeep),
        .axiRXtlast   (axiRXtlast),
        .axiRXtValid  (axiRXtValid),
        .axiCrcValid  (axiCrcValid),
        .axiCrcPass   (axiCrcPass),
        .outTdata     (outTdata),
        .outTkeep     (outTkeep),
        .outTlast     (outTlast),
        .outTvalid    (outTvalid),
        .outTready    (outTready),
        .goodPktCount (goodPktCount),
        .crcErrCount  (crcErrCount),
        .overflowCount(overflowCount)
    );

    always #5 userClk = ~userClk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [72:0] out_q [$];
    logic [72:0] exp_q [$];
    logic        rand_ready = 1'b0;
    logic        r_hold = 1'b0;
    logic [72:0] r_held;

    task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output monitor: capture every handshake and verify that a stalled
    // beat is held unchanged into the next cycle.
    always @(negedge userClk) begin
        if (!userRstN) begin
            r_hold = 1'b0;
        end else begin
            if (r_hold) begin
                check("hold_valid", 73'(outTvalid), 73'(1'b1));
                check("hold_word", {outTlast, outTkeep, outTdata}, r_held);
            end
            if (outTvalid && outTready) out_q.push_back({outTlast, outTkeep, outTdata});
            r_hold = outTvalid && !outTready;
            r_held = {outTlast, outTkeep, outTdata};
        end
    end

    task automatic tick();
        @(posedge userClk);
        #1;
        if (rand_ready) outTready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                        input logic cv, input logic cp);
        axiRXtValid = 1'b1; axiRXtdata = d; axiRXtkeep = k; axiRXtlast = l;
        axiCrcValid = cv;   axiCrcPass = cp;
        tick();
        axiRXtValid = 1'b0; axiRXtlast = 1'b0; axiCrcValid = 1'b0; axiCrcPass = 1'b0;
    endtask

    task automatic strobe(input logic pass);
        axiCrcValid = 1'b1; axiCrcPass = pass;
        tick();
        axiCrcValid = 1'b0; axiCrcPass = 1'b0;
    endtask

    // Packet of len beats with data base+i; keep 0xFF except the last beat.
    task automatic send_pkt(input logic [63:0] base, input int len, input logic [7:0] last_keep,
                            input logic push, input logic cv_on_last);
        for (int i = 0; i < len; i++) begin
            logic        last;
            logic [7:0]  k;
            logic [63:0] d;
            last = (i == len - 1);
            k    = last ? last_keep : 8'hFF;
            d    = base + 64'(i);
            if (push) exp_q.push_back({last, k, d});
            beat(d, k, last, last && cv_on_last, last && cv_on_last);
        end
    endtask

    task automatic compare_out(input string tag);
        check({tag, "_count"}, 73'(out_q.size()), 73'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check({tag, "_beat"}, out_q[i], exp_q[i]);
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        axiRXtdata = '0; axiRXtkeep = '0; axiRXtlast = 1'b0; axiRXtValid = 1'b0;
        axiCrcValid = 1'b0; axiCrcPass = 1'b0; outTready = 1'b0;

        // Reset state
        repeat (3) @(posedge userClk);
        #1;
        check("rst_valid", 73'(outTvalid), 73'(1'b0));
        check("rst_data",  73'(outTdata),  73'(64'h0));
        check("rst_keep",  73'(outTkeep),  73'(8'h0));
        check("rst_last",  73'(outTlast),  73'(1'b0));
        check("rst_good",  73'(goodPktCount),  73'(16'd0));
        check("rst_crc",   73'(crcErrCount),   73'(16'd0));
        check("rst_ovf",   73'(overflowCount), 73'(16'd0));
        userRstN = 1'b1;
        tick();
        outTready = 1'b1;

        // Good 4-beat packet, strobe one cycle after tlast, outTvalid at c+2
        send_pkt(64'hA000_0000_0000_0000, 4, 8'h0F, 1'b1, 1'b0);
        axiCrcValid = 1'b1; axiCrcPass = 1'b1;
        tick();
        axiCrcValid = 1'b0; axiCrcPass = 1'b0;
        check("t1_valid_c1", 73'(outTvalid), 73'(1'b0));
        tick();
        check("t1_valid_c2", 73'(outTvalid), 73'(1'b1));
        idle(6);
        compare_out("t1");
        check("t1_good", 73'(goodPktCount), 73'(16'd1));

        // CRC fail: nothing out; the next good packet reuses the space intact
        send_pkt(64'hB000_0000_0000_0000, 4, 8'h0F, 1'b0, 1'b0);
        strobe(1'b0);
        idle(6);
        check("t2_no_out", 73'(out_q.size()), 73'(0));
        check("t2_crc",    73'(crcErrCount),  73'(16'd1));
        check("t2_good",   73'(goodPktCount), 73'(16'd1));
        send_pkt(64'hC000_0000_0000_0000, 4, 8'h0F, 1'b1, 1'b0);
        strobe(1'b1);
        idle(8);
        compare_out("t2b");
        check("t2b_good", 73'(goodPktCount), 73'(16'd2));

        // Overflow: 10 beats into an 8-entry buffer with no reads
        outTready = 1'b0;
        send_pkt(64'hD000_0000_0000_0000, 10, 8'hFF, 1'b0, 1'b0);
        strobe(1'b1);
        idle(3);
        check("t3_ovf",   73'(overflowCount), 73'(16'd1));
        check("t3_good",  73'(goodPktCount),  73'(16'd2));
        check("t3_valid", 73'(outTvalid),     73'(1'b0));
        send_pkt(64'hE000_0000_0000_0000, 3, 8'h03, 1'b1, 1'b0);
        strobe(1'b1);
        idle(3);
        check("t3_stall_valid", 73'(outTvalid), 73'(1'b1));
        check("t3_stall_data",  73'(outTdata),  73'(64'hE000_0000_0000_0000));
        idle(3);
        check("t3_stall_data2", 73'(outTdata),  73'(64'hE000_0000_0000_0000));
        outTready = 1'b1;
        idle(6);
        compare_out("t3");
        check("t3_good2", 73'(goodPktCount),  73'(16'd3));
        check("t3_ovf2",  73'(overflowCount), 73'(16'd1));

        // Timeout: CRC_TIMEOUT waiting cycles, then a late strobe is ignored
        send_pkt(64'hF000_0000_0000_0000, 2, 8'hFF, 1'b0, 1'b0);
        idle(CT - 1);
        check("t4_before_to", 73'(crcErrCount), 73'(16'd1));
        tick();
        check("t4_after_to",  73'(crcErrCount), 73'(16'd2));
        strobe(1'b1);
        idle(4);
        check("t4_late_good",  73'(goodPktCount), 73'(16'd3));
        check("t4_late_out",   73'(out_q.size()), 73'(0));
        check("t4_late_valid", 73'(outTvalid),    73'(1'b0));

        // Orphan: A waits for CRC, B starts without a strobe, B passes
        send_pkt(64'h1A00_0000_0000_0000, 2, 8'hFF, 1'b0, 1'b0);
        send_pkt(64'h1B00_0000_0000_0000, 3, 8'h0F, 1'b1, 1'b0);
        strobe(1'b1);
        idle(8);
        compare_out("t5");
        check("t5_crc",  73'(crcErrCount),  73'(16'd3));
        check("t5_good", 73'(goodPktCount), 73'(16'd4));

        // Verdict in the tlast cycle itself
        send_pkt(64'h2000_0000_0000_0000, 1, 8'h01, 1'b1, 1'b1);
        check("t6_valid_c1", 73'(outTvalid), 73'(1'b0));
        tick();
        check("t6_valid_c2", 73'(outTvalid), 73'(1'b1));
        idle(3);
        compare_out("t6");
        check("t6_good", 73'(goodPktCount), 73'(16'd5));

        // 100 random packets under random backpressure
        rand_ready = 1'b1;
        for (int p = 0; p < 100; p++) begin
            int   len;
            int   n;
            logic same_cycle;
            len        = $urandom_range(1, 6);
            same_cycle = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                logic        last;
                logic [7:0]  k;
                logic [63:0] d;
                last = (i == len - 1);
                d    = {$urandom(), $urandom()};
                k    = last ? 8'($urandom_range(1, 255)) : 8'hFF;
                exp_q.push_back({last, k, d});
                beat(d, k, last, last && same_cycle, last && same_cycle);
            end
            if (!same_cycle) strobe(1'b1);
            n = 0;
            while (out_q.size() != exp_q.size() && n < 300) begin
                tick();
                n++;
            end
        end
        rand_ready = 1'b0;
        outTready  = 1'b1;
        idle(4);
        compare_out("t7");
        check("t7_good", 73'(goodPktCount), 73'(16'd105));

        // Asynchronous reset mid-packet with a committed beat held
        outTready = 1'b0;
        send_pkt(64'h3000_0000_0000_0000, 2, 8'hFF, 1'b0, 1'b0);
        strobe(1'b1);
        idle(3);
        check("t8_pre_valid", 73'(outTvalid),    73'(1'b1));
        check("t8_pre_good",  73'(goodPktCount), 73'(16'd106));
        beat(64'h3100_0000_0000_0000, 8'hFF, 1'b0, 1'b0, 1'b0);
        beat(64'h3100_0000_0000_0001, 8'hFF, 1'b0, 1'b0, 1'b0);
        #2;
        userRstN = 1'b0;
        #1;
        check("t8_rst_valid", 73'(outTvalid),     73'(1'b0));
        check("t8_rst_data",  73'(outTdata),      73'(64'h0));
        check("t8_rst_keep",  73'(outTkeep),      73'(8'h0));
        check("t8_rst_last",  73'(outTlast),      73'(1'b0));
        check("t8_rst_good",  73'(goodPktCount),  73'(16'd0));
        check("t8_rst_crc",   73'(crcErrCount),   73'(16'd0));
        check("t8_rst_ovf",   73'(overflowCount), 73'(16'd0));
        @(posedge userClk);
        #1;
        userRstN  = 1'b1;
        outTready = 1'b1;
        out_q.delete();
        exp_q.delete();
        idle(4);
        check("t8_post_valid", 73'(outTvalid),    73'(1'b0));
        check("t8_post_out",   73'(out_q.size()), 73'(0));
        send_pkt(64'h4000_0000_0000_0000, 2, 8'h3F, 1'b1, 1'b0);
        strobe(1'b1);
        idle(6);
        compare_out("t8");
        check("t8_good", 73'(goodPktCount), 73'(16'd1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aurora_rx_cell_filter.md
# aurora_rx_cell_filter

Receive-side packet filter between the Aurora 64b66b RX AXI-stream (user clock domain) and the cell consumer logic. Every Aurora beat is stored in a local buffer, and a packet becomes visible downstream only after the core reports a passing CRC. CRC-failed, overflowed or orphaned packets are rolled back and never appear on the output. Saturating counters report good, CRC-error and overflow packets.

## Interface
Parameters:
- ADDR_WIDTH, 5: buffer depth is 2^ADDR_WIDTH words; one word is {tlast, tkeep[7:0], tdata[63:0]} (73 bits).
- CRC_TIMEOUT, 15: number of cycles to wait for axiCrcValid after tlast; range 1..255.

Ports:
- userClk, in, 1: Aurora user clock; the only clock.
- userRstN, in, 1: asynchronous, active-low reset.
- axiRXtdata, in, 64: RX beat data.
- axiRXtkeep, in, 8: RX byte enables.
- axiRXtlast, in, 1: last beat of packet.
- axiRXtValid, in, 1: beat valid. There is no ready; every valid beat must be accepted.
- axiCrcValid, in, 1: CRC result strobe.
- axiCrcPass, in, 1: CRC pass; qualified by axiCrcValid.
- outTdata, out, 64: filtered stream data.
- outTkeep, out, 8: filtered stream byte enables.
- outTlast, out, 1: filtered stream last beat.
- outTvalid, out, 1: filtered stream valid.
- outTready, in, 1: downstream ready.
- goodPktCount, out, 16: saturating count of packets committed.
- crcErrCount, out, 16: saturating count of packets discarded for CRC fail, timeout or orphan.
- overflowCount, out, 16: saturating count of packets dropped because the buffer was full.

## Operation
- Pointers are ADDR_WIDTH+1 bits wide: wrPtr, commitPtr, rdPtr.
- full is (wrPtr − rdPtr) == 2^ADDR_WIDTH.
- Committed data is available when commitPtr != rdPtr.
- States and transitions:
  - IDLE:
    - A valid beat writes at wrPtr, increments wrPtr and goes to RECV.
    - If that beat also has tlast, go to WAIT_CRC instead.
    - axiCrcValid is ignored in IDLE.
  - RECV:
    - Each valid beat is written and wrPtr increments.
    - A beat with tlast goes to WAIT_CRC.
  - WAIT_CRC:
    - axiCrcValid & axiCrcPass: commitPtr <= wrPtr, goodPktCount++, go to IDLE.
    - axiCrcValid & !axiCrcPass: wrPtr <= commitPtr (rollback), crcErrCount++, go to IDLE.
    - Timer reaching CRC_TIMEOUT: same as a CRC fail.
    - Valid beat arriving with no axiCrcValid (orphan): roll back the pending packet and crcErrCount++. The new beat is written at commitPtr, wrPtr <= commitPtr+1, and the state goes to RECV (or WAIT_CRC if the beat has tlast).
  - DROP:
    - Beats are discarded.
    - tlast returns to IDLE. That packet's CRC strobe then lands in IDLE and is ignored.
- axiCrcValid in the tlast cycle itself is honoured. The result is applied directly and the FSM stays in IDLE without visiting WAIT_CRC.
- Overflow: a valid beat while full (any state that writes) is not written, wrPtr <= commitPtr, overflowCount++.
  - Next state is DROP, or IDLE if the beat has tlast.
  - An overflow beat in WAIT_CRC first applies the orphan rollback, counting crcErrCount++ as well, then re-evaluates full against the rolled-back pointer. If the beat fits, it is written as a normal orphan-case beat.
- Read side: a one-entry output register (skid-free) is loaded from the buffer when empty or when (outTvalid & outTready). The read is first-word-fall-through via registered memory read plus prefetch; sustained throughput is 1 beat/cycle.
- Counters saturate at 0xFFFF.

## Timing
- Reset values:
  - outTvalid = 0.
  - outTdata, outTkeep, outTlast = 0.
  - All counters = 0.
  - All pointers = 0.
  - State = IDLE, timer = 0.
- Reset is asserted asynchronously and released synchronously (the input is assumed externally synchronised). Reset mid-packet discards all buffered and committed data.
- Commit latency: axiCrcValid sampled in cycle c → commitPtr updates at the end of c → outTvalid = 1 in cycle c+2 when the output register is empty.
- Timer: starts at 0 in the cycle after tlast and increments every WAIT_CRC cycle. Timeout fires in the cycle the timer equals CRC_TIMEOUT−1 with no strobe.
- Output holds data/keep/last stable while outTvalid & !outTready.
- Write and rollback in the same cycle are resolved as stated; commit and read in the same cycle are independent.

## Test plan
- 4-beat packet (tlast on beat 4, tkeep 0xFF, last tkeep 0x0F), axiCrcValid/Pass 1 cycle after tlast, outTready=1 → 4 beats out, identical data, outTvalid high 2 cycles after the strobe, goodPktCount=1.
- Same packet with axiCrcPass=0 → no output, crcErrCount=1. A following good packet emerges intact, with its first beat at the old start address.
- ADDR_WIDTH=3, outTready=0, 10-beat packet → overflowCount=1, no output. After tlast, a good 3-beat packet commits and outputs only those 3 beats.
- No CRC strobe after tlast → timeout after CRC_TIMEOUT cycles, crcErrCount=1, buffer empty. A late strobe in IDLE changes nothing.
- Packet A in WAIT_CRC, then packet B's first beat arrives with no strobe, then B passes CRC → A discarded (crcErrCount=1), B output only (goodPktCount=1).
- Random outTready toggling across 100 good packets → output equals input stream exactly, no duplicated or lost beats. Assert userRstN low mid-packet → all outputs at reset values the same cycle.
